// File: rtl/toggle_event_decoder_if.sv
// Event handshake bundle between the toggle event decoder (master) and its consumer (slave).
interface toggle_event_decoder_if #(
  parameter int PEND_W = 2
);
  logic              event_ready;
  logic              event_valid;
  logic [PEND_W-1:0] pending;

  modport master (input event_ready, output event_valid, output pending);
  modport slave  (output event_ready, input event_valid, input pending);
endinterface

// File: rtl/toggle_event_decoder.sv
// Receive end of a toggle-signalling event link: synchronise, detect, queue and count events.
// Optional glitch filter enabled by defining TOGGLE_EVENT_DECODER_FILTER_EN.
module toggle_event_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 8,
  parameter int PEND_W        = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  toggle_in,
  input  logic                  clear_stats,
  output logic                  level_out,
  output logic                  pulse_out,
  output logic [CNT_W-1:0]      event_count,
  output logic                  overflow,
  toggle_event_decoder_if.master evt
);

  localparam logic [PEND_W-1:0] MAX_PEND = '1;

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  logic                   differ;
  logic                   det;
  logic                   acc;
  logic                   drop;
  logic                   valid_q;
  logic [PEND_W-1:0]      pend_q, pend_nxt;

  assign sync_q = sync_chain[SYNC_STAGES-1];
  assign differ = (sync_q != level_out);
  assign acc    = valid_q & evt.event_ready;

`ifdef TOGGLE_EVENT_DECODER_FILTER_EN
  // A change is only believed once it has persisted for FILTER_CYCLES cycles.
  logic [3:0] stable_cnt;

  assign det = differ && (stable_cnt == 4'(FILTER_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_cnt <= '0;
    end else if (!differ || det) begin
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 4'(1);
    end
  end
`else
  assign det = differ;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_chain <= '0;
      level_out  <= 1'b0;
      pulse_out  <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], toggle_in};
      pulse_out  <= det;
      if (det) begin
        level_out <= sync_q;
      end
    end
  end

  // Queue occupancy: a detect and an accept in the same cycle cancel, so FULL never drops then.
  always_comb begin
    pend_nxt = pend_q;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (det) pend_nxt = pend_q + PEND_W'(1);
      end
      BUSY: begin
        if (det && !acc)      pend_nxt = pend_q + PEND_W'(1);
        else if (!det && acc) pend_nxt = pend_q - PEND_W'(1);
      end
      FULL: begin
        if (det && !acc)      drop     = 1'b1;
        else if (!det && acc) pend_nxt = pend_q - PEND_W'(1);
      end
      default: pend_nxt = '0;
    endcase

    if (pend_nxt == '0)            state_nxt = IDLE;
    else if (pend_nxt == MAX_PEND) state_nxt = FULL;
    else                           state_nxt = BUSY;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pend_q      <= '0;
      valid_q     <= 1'b0;
      event_count <= '0;
      overflow    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend_q  <= pend_nxt;
      valid_q <= (pend_nxt != '0);

      if (clear_stats) begin
        event_count <= det ? CNT_W'(1) : '0;
      end else if (det) begin
        event_count <= event_count + CNT_W'(1);
      end

      // A drop in the clearing cycle must still be reported.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_stats) begin
        overflow <= 1'b0;
      end
    end
  end

  assign evt.event_valid = valid_q;
  assign evt.pending     = pend_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Randomised self-checking bench for toggle_event_decoder against an event-schedule reference model.
module tb_toggle_event_decoder;

  localparam int SYNC_STAGES   = 2;
  localparam int CNT_W         = 8;
  localparam int PEND_W        = 2;
  localparam int FILTER_CYCLES = 3;
  localparam int MAXP          = (1 << PEND_W) - 1;
`ifdef TOGGLE_EVENT_DECODER_FILTER_EN
  localparam int LAT = SYNC_STAGES + FILTER_CYCLES - 1;
  localparam int GAP = SYNC_STAGES + FILTER_CYCLES + 1;
`else
  localparam int LAT = SYNC_STAGES;
  localparam int GAP = SYNC_STAGES + 2;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             toggle_in = 1'b0;
  logic             clear_stats = 1'b0;
  logic             level_out;
  logic             pulse_out;
  logic [CNT_W-1:0] event_count;
  logic             overflow;

  toggle_event_decoder_if #(.PEND_W(PEND_W)) ev_if ();

  toggle_event_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W(CNT_W),
    .PEND_W(PEND_W),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .toggle_in(toggle_in),
    .clear_stats(clear_stats),
    .level_out(level_out),
    .pulse_out(pulse_out),
    .event_count(event_count),
    .overflow(overflow),
    .evt(ev_if.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int since_change = 100;

  // Reference model: each sampled level change is scheduled to be seen LAT edges later.
  int det_at[$];
  int sample_at[$];
  bit sched_level = 1'b0;
  int m_pending = 0;
  int m_count = 0;
  bit m_level = 1'b0;
  bit m_pulse = 1'b0;
  bit m_ovf = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic modelEdge();
    bit det;
    bit acc;
    bit drop;
    edge_n++;
    if (!reset_n) begin
      m_pending = 0;
      m_count = 0;
      m_level = 1'b0;
      m_pulse = 1'b0;
      m_ovf = 1'b0;
      sched_level = 1'b0;
      det_at.delete();
      sample_at.delete();
    end else begin
      det = (det_at.size() > 0) && (det_at[0] == edge_n);
      if (det) begin
        void'(det_at.pop_front());
        void'(sample_at.pop_front());
      end
      acc  = (m_pending > 0) && ev_if.event_ready;
      drop = det && !acc && (m_pending == MAXP);
      if (det && !acc && !drop) m_pending++;
      else if (!det && acc)     m_pending--;
      if (drop)             m_ovf = 1'b1;
      else if (clear_stats) m_ovf = 1'b0;
      if (clear_stats)      m_count = det ? 1 : 0;
      else if (det)         m_count = (m_count + 1) % (1 << CNT_W);
      if (det) m_level = ~m_level;
      m_pulse = det;
      if (toggle_in != sched_level) begin
`ifdef TOGGLE_EVENT_DECODER_FILTER_EN
        if (sample_at.size() > 0 && (edge_n - sample_at[$]) < FILTER_CYCLES) begin
          void'(det_at.pop_back());
          void'(sample_at.pop_back());
        end else begin
          det_at.push_back(edge_n + LAT);
          sample_at.push_back(edge_n);
        end
`else
        det_at.push_back(edge_n + LAT);
        sample_at.push_back(edge_n);
`endif
        sched_level = toggle_in;
      end
    end
  endtask

  task automatic applyStimulus(input bit flip, input bit ready, input bit clr, input bit rst_n);
    @(negedge clk);
    if (flip) toggle_in = ~toggle_in;
    ev_if.event_ready = ready;
    clear_stats = clr;
    reset_n = rst_n;
    since_change = flip ? 0 : since_change + 1;
    @(posedge clk);
    #1;
    modelEdge();
    checkOutput("pulse_out",   32'(pulse_out),         32'(m_pulse));
    checkOutput("level_out",   32'(level_out),         32'(m_level));
    checkOutput("pending",     32'(ev_if.pending),     32'(m_pending));
    checkOutput("event_valid", 32'(ev_if.event_valid), 32'(m_pending != 0));
    checkOutput("event_count", 32'(event_count),       32'(m_count));
    checkOutput("overflow",    32'(overflow),          32'(m_ovf));
  endtask

  task automatic doToggle(input bit ready);
    applyStimulus(1'b1, ready, 1'b0, 1'b1);
    repeat (GAP - 1) applyStimulus(1'b0, ready, 1'b0, 1'b1);
  endtask

  task automatic drain();
    repeat (MAXP + LAT + 2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  function automatic bit canFlip();
    return since_change >= GAP - 1;
  endfunction

  initial begin
    ev_if.event_ready = 1'b0;

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // single toggle, then fill past capacity
    doToggle(1'b0);
    repeat (4) doToggle(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // detect and accept together while FULL
    for (int i = 0; i < GAP; i++) applyStimulus(i == 0, i == LAT, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++)
      applyStimulus(canFlip() && ($urandom_range(0, 1) == 1), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 31) == 0, 1'b1);

    drain();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (260) doToggle(1'b1);

    // reset with two events queued and toggle_in high
    drain();
    if (toggle_in == 1'b0) begin
      doToggle(1'b1);
      drain();
    end
    doToggle(1'b0);
    doToggle(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef TOGGLE_EVENT_DECODER_FILTER_EN
    repeat (GAP) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (GAP + 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    doToggle(1'b0);
`endif

    for (int i = 0; i < 600; i++)
      applyStimulus(canFlip() && ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
- Receive side of the toggle-signalling scheme: each level change on `toggle_in` from a remote toggle FSM is one event.
- Synchronises `toggle_in` into `clk`, detects each change, and emits a one-cycle pulse.
- Queues events behind a valid/ready handshake, keeps a wrap-around event counter, and flags dropped events with a sticky overflow.
- Sits at the consumer end of any toggle-based cross-domain event link.

Parameters:
- SYNC_STAGES, 2, synchroniser flop count on `toggle_in` (legal 2..4).
- CNT_W, 8, width of `event_count`.
- PEND_W, 2, width of `pending`; queue holds up to 2^PEND_W-1 events (3 by default).
- FILTER_CYCLES, 3, stability requirement in cycles; used only with the optional feature (legal 2..15).

Ports:
- clk  input  1  sole clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- toggle_in  input  1  toggling level from the remote toggle FSM; asynchronous to clk
- event_ready  input  1  consumer accepts an event when high with event_valid
- clear_stats  input  1  one-cycle clear of event_count and overflow
- level_out  output  1  decoder's copy of the remote state (registered reference level)
- pulse_out  output  1  one-cycle pulse per detected toggle
- event_valid  output  1  high while pending != 0
- pending  output  PEND_W  number of queued, unaccepted events
- event_count  output  CNT_W  total detected toggles, wraps modulo 2^CNT_W
- overflow  output  1  sticky: a detected event was dropped because the queue was full

Behaviour:
- Reset: reset_n low at a rising edge forces all of the following to 0:
  - sync chain, level_out, pulse_out, pending, event_count, overflow, FSM state (IDLE).
  - Because level_out resets to 0, the link is assumed to reset with the remote toggle FSM at 0.
- Reset mid-operation: queued events are discarded. Any toggle_in level that is still 1 after reset is detected as a new event normally.
- Synchroniser: a plain shift chain; sync_q is its last stage.
- Detection: det = (sync_q != level_out). On det, level_out <= sync_q and pulse_out <= 1 at the same edge; otherwise pulse_out <= 0.
- Latency: toggle_in stable before edge E0 -> sync_q updates at E0+SYNC_STAGES-1 -> pulse_out and level_out update at E0+SYNC_STAGES.
  - With the default of 2, pulse_out is high for the cycle after E0+2.
- Minimum toggle spacing for lossless decoding: SYNC_STAGES+1 cycles. Two changes inside the synchroniser window can cancel, and are then not detected.
- Queue FSM, with states IDLE (pending=0), BUSY (0<pending<MAX) and FULL (pending=MAX=2^PEND_W-1). acc = event_valid & event_ready. All updates are registered on det/acc:

  | det | acc | effect |
  |-----|-----|--------|
  | 1 | 0 | pending+1; if FULL, pending stays MAX, event is dropped, overflow <= 1 |
  | 0 | 1 | pending-1 |
  | 1 | 1 | pending unchanged, including in FULL (no drop) |
  | 0 | 0 | hold |

  - event_ready while IDLE has no effect.
  - State is a pure function of pending after each edge.
- event_count:
  - Increments on every det, including dropped events.
  - Wraps from 2^CNT_W-1 to 0.
  - clear_stats with det in the same cycle gives event_count = 1.
- overflow: clear_stats clears it. If a drop occurs in the same cycle as clear_stats, the set wins and overflow = 1.
- clear_stats does not affect pending, level_out or the sync chain.
- All outputs are registered.

Optional Feature:
- Macro: TOGGLE_EVENT_DECODER_FILTER_EN.
- When defined:
  - A glitch filter sits between sync_q and detection, using a stability counter sized for FILTER_CYCLES.
  - det fires only after sync_q has differed from level_out for FILTER_CYCLES consecutive cycles.
  - Any cycle with sync_q == level_out resets the counter to 0, so shorter excursions are ignored.
  - Latency grows by FILTER_CYCLES-1 cycles.
  - Minimum toggle spacing becomes SYNC_STAGES+FILTER_CYCLES cycles.
  - The counter resets to 0.
- When not defined:
  - No filter logic is present.
  - Detection, latency and spacing are exactly as described in Behaviour.

Test Plan:
- Reset then single toggle:
  - Stimulus: reset_n low for 2 cycles; toggle_in 0->1 before edge E0; event_ready=0; default parameters.
  - Response: pulse_out high only in the cycle after E0+2; level_out=1; pending=1; event_valid=1; event_count=1.
- Handshake drain:
  - Stimulus: 2 toggles spaced 4 cycles apart, then event_ready=1 for 3 cycles.
  - Response: pending goes 1, 2, then 1, 0; event_valid drops after the second accept; the third ready cycle has no effect.
- Overflow:
  - Stimulus: event_ready=0; 4 toggles spaced 4 cycles apart.
  - Response: pending saturates at 3; overflow=1 after the 4th detection; event_count=4.
  - Then pulse clear_stats: overflow=0, event_count=0, pending stays 3.
- Simultaneous detect and accept at FULL:
  - Stimulus: pending=3; event_ready=1 in the same cycle that det=1.
  - Response: pending stays 3; overflow stays 0.
- Counter wrap and reset mid-operation:
  - Stimulus: 256 toggles spaced 4 apart with event_ready=1, then event_count=0.
  - Response: event_count=0 after 256 toggles (wrap).
  - Stimulus: with pending=2, assert reset_n low for 1 cycle while toggle_in=1.
  - Response: all outputs 0 after the reset edge; one new event is detected 3 edges after reset releases; level_out=1.
- Filter (macro defined, FILTER_CYCLES=3):
  - Stimulus: a 2-cycle high glitch on toggle_in.
  - Response: no pulse_out; event_count=0.
  - Stimulus: a stable toggle.
  - Response: pulse_out appears at E0+4.
